// File: rtl/mpu_add_seq_pkg.sv
// Shared constants, state encoding and element-offset helper for the 5x5 matrix adder sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mpu_add_seq_pkg;

    localparam int MPU_DIM   = 5;
    localparam int MPU_EW    = 8;
    localparam int MPU_ELEMS = MPU_DIM * MPU_DIM;

    // Sequencer states; 3-bit encoding is shared with the host-side tooling
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_EXEC   = 3'd3,
        ST_DRAIN  = 3'd4
    } state_t;

    // Bit offset of element (i,j) in a flattened matrix; column-major stream order
    function automatic int elem_at(input int i, input int j);
        return MPU_EW * (i + MPU_DIM * j);
    endfunction

endpackage

// File: rtl/mpu_byte_buf.sv
// ELEMS x EW register file: indexed element write, whole-matrix parallel load, flat read-out.
// Latency: writes visible on the flat output the cycle after the write.
// Backpressure: none; the caller qualifies writes with its own handshake.
module mpu_byte_buf
    import mpu_add_seq_pkg::*;
#(
    parameter int ELEMS = MPU_ELEMS,
    parameter int EW    = MPU_EW,
    parameter int IDXW  = $clog2(ELEMS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [IDXW-1:0]       wr_idx,
    input  logic [EW-1:0]         wr_dat,
    input  logic                  ld_en,
    input  logic [EW*ELEMS-1:0]   ld_dat,
    output logic [EW*ELEMS-1:0]   flat
);

    logic [EW*ELEMS-1:0] mem;

    // Storage: parallel load wins over a single-element write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
        end else if (ld_en) begin
            mem <= ld_dat;
        end else if (wr_en) begin
            mem[EW*int'(wr_idx) +: EW] <= wr_dat;
        end
    end

    assign flat = mem;

endmodule

// File: rtl/mpu_add_seq.sv
// Sequencer for the element-wise matrix adder: byte-stream load of A then B, one-cycle capture of the sum, byte-stream drain.
// Latency: start -> done is 2*ELEMS + 1 + ELEMS + 1 cycles with no stalls (77 for 5x5).
// Backpressure: in_valid low or out_ready low freezes state and index; out_data held stable while stalled.
module mpu_add_seq
    import mpu_add_seq_pkg::*;
#(
    parameter int DIM = MPU_DIM,
    parameter int EW  = MPU_EW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [EW-1:0]           in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [EW*DIM*DIM-1:0]   op_a,
    output logic [EW*DIM*DIM-1:0]   op_b,
    input  logic [EW*DIM*DIM-1:0]   op_sum,
    output logic [EW-1:0]           out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done
);

    localparam int ELEMS = DIM * DIM;
    localparam int IDXW  = $clog2(ELEMS);
    localparam logic [IDXW-1:0] LAST = IDXW'(ELEMS - 1);

    state_t            state, state_nxt;
    logic [IDXW-1:0]   idx, idx_nxt;
    logic              done_q, done_nxt;
    logic              a_we, b_we, r_ld;
    logic [EW*ELEMS-1:0] res_flat;

    // State, index and done pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            idx    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            done_q <= done_nxt;
        end
    end

    // Next-state, handshake qualifiers and buffer write enables; abort overrides everything
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        done_nxt  = 1'b0;
        a_we      = 1'b0;
        b_we      = 1'b0;
        r_ld      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        if (abort) begin
            state_nxt = ST_IDLE;
            idx_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_nxt = ST_LOAD_A;
                        idx_nxt   = '0;
                    end
                end
                ST_LOAD_A: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        a_we = 1'b1;
                        if (idx == LAST) begin
                            state_nxt = ST_LOAD_B;
                            idx_nxt   = '0;
                        end else begin
                            idx_nxt = idx + IDXW'(1);
                        end
                    end
                end
                ST_LOAD_B: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        b_we = 1'b1;
                        if (idx == LAST) begin
                            state_nxt = ST_EXEC;
                            idx_nxt   = '0;
                        end else begin
                            idx_nxt = idx + IDXW'(1);
                        end
                    end
                end
                ST_EXEC: begin
                    // Adder owns the per-element wrap; capture its output verbatim
                    r_ld      = 1'b1;
                    state_nxt = ST_DRAIN;
                    idx_nxt   = '0;
                end
                ST_DRAIN: begin
                    out_valid = 1'b1;
                    if (out_ready) begin
                        if (idx == LAST) begin
                            state_nxt = ST_IDLE;
                            idx_nxt   = '0;
                            done_nxt  = 1'b1;
                        end else begin
                            idx_nxt = idx + IDXW'(1);
                        end
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    idx_nxt   = '0;
                end
            endcase
        end
    end

    mpu_byte_buf #(.ELEMS(ELEMS), .EW(EW), .IDXW(IDXW)) u_buf_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (a_we),
        .wr_idx (idx),
        .wr_dat (in_data),
        .ld_en  (1'b0),
        .ld_dat ('0),
        .flat   (op_a)
    );

    mpu_byte_buf #(.ELEMS(ELEMS), .EW(EW), .IDXW(IDXW)) u_buf_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (b_we),
        .wr_idx (idx),
        .wr_dat (in_data),
        .ld_en  (1'b0),
        .ld_dat ('0),
        .flat   (op_b)
    );

    mpu_byte_buf #(.ELEMS(ELEMS), .EW(EW), .IDXW(IDXW)) u_buf_r (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (1'b0),
        .wr_idx (idx),
        .wr_dat ('0),
        .ld_en  (r_ld),
        .ld_dat (op_sum),
        .flat   (res_flat)
    );

    // Output element comes straight from the result registers; forced to zero outside DRAIN
    always_comb begin
        out_data = '0;
        if (state == ST_DRAIN) begin
            out_data = res_flat[EW*int'(idx) +: EW];
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_mpu_add_seq.sv
module tb_mpu_add_seq;

    localparam int DIM   = 5;
    localparam int EW    = 8;
    localparam int ELEMS = DIM * DIM;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic                  abort;
    logic [EW-1:0]         in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [EW*ELEMS-1:0]   op_a;
    logic [EW*ELEMS-1:0]   op_b;
    logic [EW*ELEMS-1:0]   op_sum;
    logic [EW-1:0]         out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  busy;
    logic                  done;

    mpu_add_seq #(.DIM(DIM), .EW(EW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sum    (op_sum),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    // Combinational element-wise adder, wrapping mod 2^EW per element
    for (genvar e = 0; e < ELEMS; e++) begin : g_add
        assign op_sum[EW*e +: EW] = op_a[EW*e +: EW] + op_b[EW*e +: EW];
    end

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [7:0]  a0;
        int          a_step;
        logic [7:0]  b0;
        int          b_step;
        bit          gaps;
        bit          pulse_start;
        bit          chk_lat;
    } vec_t;

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          t0 = 0;
    int          hs_cnt = 0;
    int          done_cnt = 0;
    int          done_cyc = -1;
    bit          gaps = 1'b0;
    logic [7:0]  src[2*ELEMS];
    logic [7:0]  exp_q[$];
    vec_t        vecs[5];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard side: compare every presented element to the queue head, pop on handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("out_unexpected", 32'(out_valid), 32'd0);
                end else begin
                    check("out_data", 32'(out_data), 32'(exp_q[0]));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        hs_cnt++;
                    end
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // Downstream ready: continuous or ~50% random
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic feed(input bit g, input int n);
        int  k = 0;
        int  guard = 0;
        bit  hs;
        while (k < n && guard < 5000) begin
            in_valid = g ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = src[k];
            @(negedge clk);
            hs = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (hs) k++;
            guard++;
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic pulse_start_at(input int c);
        while (cyc < t0 + c) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic load_src(input vec_t v, input bit push);
        logic [7:0] a, b, s;
        for (int k = 0; k < ELEMS; k++) begin
            a = 8'(int'(v.a0) + v.a_step * k);
            b = 8'(int'(v.b0) + v.b_step * k);
            s = 8'(int'(a) + int'(b));
            src[k]         = a;
            src[ELEMS + k] = b;
            if (push) exp_q.push_back(s);
        end
    endtask

    task automatic do_start();
        @(posedge clk);
        #1;
        start = 1'b1;
        t0    = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_op(input vec_t v);
        int guard = 0;
        load_src(v, 1'b1);
        gaps     = v.gaps;
        hs_cnt   = 0;
        done_cnt = 0;
        done_cyc = -1;
        do_start();
        fork
            feed(v.gaps, 2 * ELEMS);
            if (v.pulse_start) begin
                pulse_start_at(30);
                pulse_start_at(60);
            end
        join
        while (done_cnt == 0 && guard < 3000) begin
            @(posedge clk);
            guard++;
        end
        #1;
        check({v.name, "_done_count"}, 32'(done_cnt), 32'd1);
        if (v.chk_lat) check({v.name, "_done_cycle"}, 32'(done_cyc - t0), 32'd77);
        check({v.name, "_out_handshakes"}, 32'(hs_cnt), 32'(ELEMS));
        check({v.name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        check({v.name, "_busy_after"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check({v.name, "_done_one_cycle"}, 32'(done), 32'd0);
        gaps = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;

        vecs[0] = '{"ramp",     8'd1,   1,  8'd25,  -1, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{"wrap",     8'd200, 0,  8'd100,  0, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{"gaps",     8'd0,   1,  8'd0,    2, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{"startign", 8'd7,   3,  8'd250,  5, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{"zeros",    8'd0,   0,  8'd0,    0, 1'b0, 1'b0, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_op_ab_zero", 32'((op_a == '0) && (op_b == '0)), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Input offered while idle must not be accepted
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 8'h5a;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("idle_busy", 32'(busy), 32'd0);

        // Table-driven full operations
        for (int v = 0; v < 4; v++) begin
            run_op(vecs[v]);
            if (v == 0) begin
                check("layout_a_4_0", 32'(op_a[EW*(4 + DIM*0) +: EW]), 32'(1 + 4));
                check("layout_a_0_1", 32'(op_a[EW*(0 + DIM*1) +: EW]), 32'(1 + 5));
                check("layout_a_4_4", 32'(op_a[EW*(4 + DIM*4) +: EW]), 32'(1 + 24));
                check("layout_b_2_3", 32'(op_b[EW*(2 + DIM*3) +: EW]), 32'(25 - 17));
            end
        end

        // Abort after 10 B elements, then a clean all-zero operation
        load_src(vecs[3], 1'b0);
        done_cnt = 0;
        do_start();
        feed(1'b0, ELEMS + 10);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_keeps_a", 32'(op_a[EW*3 +: EW]), 32'(7 + 3*3));
        run_op(vecs[4]);

        // Asynchronous reset mid-drain
        load_src(vecs[2], 1'b1);
        hs_cnt   = 0;
        done_cnt = 0;
        do_start();
        feed(1'b0, 2 * ELEMS);
        for (int g = 0; g < 200 && hs_cnt < 5; g++) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_out_data", 32'(out_data), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_op_zero", 32'((op_a == '0) && (op_b == '0)), 32'd1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("arst_release_out_valid", 32'(out_valid), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("arst_no_done", 32'(done_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
